sti_dac_param: RTL and testbench

Parametrised serial transmitter and data-arrange controller: the next generation of the fixed 16-bit/256-byte STI/DAC block. It accepts one parallel word per load handshake and shapes it to 1..2^LW bytes. It shifts the shaped word out serially, then scatters its bytes one per cycle into BANKS odd/even memory pairs using a checkerboard pattern. It sits between the host load interface and the bank SRAMs, and raises a sticky finish flag when the memory image is complete.

---
 rtl/sti_dac_param.sv | 204 ++++++++++++++++++++
 tb/tb_sti_dac_param.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sti_dac_param.sv
// Parametrised serial transmitter and checkerboard data-arrange controller.
// Define STI_DAC_ZERO_FILL_EN to zero-fill unwritten bytes after the end word.
module sti_dac_param #(
    parameter int unsigned DW        = 16,
    parameter int unsigned LW        = 2,
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned BANKS     = 4,
    localparam int unsigned AW       = $clog2(MEM_DEPTH / (2 * BANKS))
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    output logic             in_ready,
    input  logic [DW-1:0]    pi_data,
    input  logic [LW-1:0]    pi_length,
    input  logic             pi_fill,
    input  logic             pi_msb,
    input  logic             pi_low,
    input  logic             pi_end,
    output logic             so_data,
    output logic             so_valid,
    output logic [7:0]       oem_dataout,
    output logic [AW-1:0]    oem_addr,
    output logic [BANKS-1:0] odd_wr,
    output logic [BANKS-1:0] even_wr,
    output logic             oem_finish
);

    localparam int unsigned NMAX = 8 * (2 ** LW);
    localparam int unsigned IW   = $clog2(NMAX);
    localparam int unsigned BIW  = IW + 1;
    localparam int unsigned CW   = LW + 1;
    localparam int unsigned KW   = $clog2(MEM_DEPTH) + 1;
    localparam int unsigned GSH  = $clog2(MEM_DEPTH / BANKS);

    typedef enum logic [2:0] {IDLE, SHIFT, WRITE, FILL, DONE} state_t;

    state_t            state;
    logic [NMAX-1:0]   ser_q;
    logic [LW-1:0]     len_q;
    logic              end_q;
    logic [BIW-1:0]    bit_idx;
    logic [CW-1:0]     byte_idx;
    logic [KW-1:0]     k;

    logic [NMAX-1:0]   shaped_c;
    logic [BIW-1:0]    n_q;
    logic [CW-1:0]     l_q;
    logic              k_room;
    logic              odd_sel;
    logic [BANKS-1:0]  bank_sel;
    logic              fill_go;
    logic              do_wr;
    logic [7:0]        wr_byte;

    // Shaped word in transmit order: bit i of the result is serial bit i.
    function automatic logic [NMAX-1:0] shape_serial(input logic [DW-1:0] d,
                                                     input logic [LW-1:0] len,
                                                     input logic fill,
                                                     input logic msb,
                                                     input logic low);
        int unsigned     n;
        logic [NMAX-1:0] v;
        logic [NMAX-1:0] rev;
        n = 8 * (32'(len) + 1);
        if (n < DW)
            v = low ? NMAX'(d >> (DW - n)) : (NMAX'(d) & ~({NMAX{1'b1}} << n));
        else
            v = fill ? (NMAX'(d) << (n - DW)) : NMAX'(d);
        rev = {<<{v}};
        return msb ? (rev >> (NMAX - n)) : v;
    endfunction

    // Memory byte idx: serial bits 8*idx.., first-sent bit lands in bit 7.
    function automatic logic [7:0] byte_of(input logic [NMAX-1:0] s,
                                           input logic [CW-1:0] idx);
        logic [NMAX-1:0] c;
        logic [7:0]      b;
        c = s >> {idx, 3'b000};
        b = c[7:0];
        return {<<{b}};
    endfunction

    assign shaped_c = shape_serial(pi_data, pi_length, pi_fill, pi_msb, pi_low);
    assign n_q      = BIW'(8 * (32'(len_q) + 1));
    assign l_q      = CW'(len_q) + CW'(1);
    assign k_room   = (k < KW'(MEM_DEPTH));
    assign odd_sel  = (k[0] == k[3]);
    assign bank_sel = BANKS'(1) << (k >> GSH);

`ifdef STI_DAC_ZERO_FILL_EN
    assign fill_go = k_room;
`else
    assign fill_go = 1'b0;
`endif

    // Byte to be written on the coming edge, if any.
    always_comb begin
        do_wr   = 1'b0;
        wr_byte = 8'h00;
        case (state)
            SHIFT: begin
                if (bit_idx == n_q) begin
                    do_wr   = 1'b1;
                    wr_byte = byte_of(ser_q, CW'(0));
                end
            end
            WRITE: begin
                if (byte_idx != l_q) begin
                    do_wr   = 1'b1;
                    wr_byte = byte_of(ser_q, byte_idx);
                end else if (end_q && fill_go) begin
                    do_wr = 1'b1;
                end
            end
            FILL:    do_wr = k_room;
            default: do_wr = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ser_q       <= '0;
            len_q       <= '0;
            end_q       <= 1'b0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            k           <= '0;
            in_ready    <= 1'b1;
            so_data     <= 1'b0;
            so_valid    <= 1'b0;
            oem_dataout <= 8'h00;
            oem_addr    <= '0;
            odd_wr      <= '0;
            even_wr     <= '0;
            oem_finish  <= 1'b0;
        end else begin
            // Saturated counter suppresses strobes but not the serial stream.
            if (do_wr && k_room) begin
                odd_wr      <= odd_sel ? bank_sel : '0;
                even_wr     <= odd_sel ? '0 : bank_sel;
                oem_addr    <= k[GSH-1:1];
                oem_dataout <= wr_byte;
                k           <= k + KW'(1);
            end else begin
                odd_wr      <= '0;
                even_wr     <= '0;
                oem_addr    <= '0;
                oem_dataout <= 8'h00;
            end

            case (state)
                IDLE: begin
                    if (load) begin
                        ser_q    <= shaped_c;
                        len_q    <= pi_length;
                        end_q    <= pi_end;
                        so_valid <= 1'b1;
                        so_data  <= shaped_c[0];
                        bit_idx  <= BIW'(1);
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_idx == n_q) begin
                        so_valid <= 1'b0;
                        so_data  <= 1'b0;
                        byte_idx <= CW'(1);
                        state    <= WRITE;
                    end else begin
                        so_data <= ser_q[bit_idx[IW-1:0]];
                        bit_idx <= bit_idx + BIW'(1);
                    end
                end
                WRITE: begin
                    if (byte_idx == l_q) begin
                        if (!end_q) begin
                            in_ready <= 1'b1;
                            state    <= IDLE;
                        end else if (fill_go) begin
                            state <= FILL;
                        end else begin
                            oem_finish <= 1'b1;
                            state      <= DONE;
                        end
                    end else begin
                        byte_idx <= byte_idx + CW'(1);
                    end
                end
                FILL: begin
                    if (!k_room) begin
                        oem_finish <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sti_dac_param.sv
// Scoreboard bench for sti_dac_param: serial bits and bank writes checked with cycle stamps.
module tb_sti_dac_param;

    localparam int DW        = 16;
    localparam int LW        = 2;
    localparam int MEM_DEPTH = 256;
    localparam int BANKS     = 4;
    localparam int AW        = 5;
    localparam int GRP       = MEM_DEPTH / BANKS;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             load = 1'b0;
    logic             in_ready;
    logic [DW-1:0]    pi_data = '0;
    logic [LW-1:0]    pi_length = '0;
    logic             pi_fill = 1'b0;
    logic             pi_msb = 1'b0;
    logic             pi_low = 1'b0;
    logic             pi_end = 1'b0;
    logic             so_data;
    logic             so_valid;
    logic [7:0]       oem_dataout;
    logic [AW-1:0]    oem_addr;
    logic [BANKS-1:0] odd_wr;
    logic [BANKS-1:0] even_wr;
    logic             oem_finish;

    sti_dac_param dut (
        .clk(clk), .reset(reset), .load(load), .in_ready(in_ready),
        .pi_data(pi_data), .pi_length(pi_length), .pi_fill(pi_fill),
        .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
        .so_data(so_data), .so_valid(so_valid), .oem_dataout(oem_dataout),
        .oem_addr(oem_addr), .odd_wr(odd_wr), .even_wr(even_wr),
        .oem_finish(oem_finish)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_bits[$];
    logic [63:0] exp_wr[$];
    int          mk = 0;
    int          exp_rdy = -1;
    int          exp_fin = -1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] pack_wr(input int c, input logic [3:0] o,
                                            input logic [3:0] e, input logic [4:0] a,
                                            input logic [7:0] d);
        return 64'({32'(c), o, e, a, d});
    endfunction

    function automatic logic [31:0] model_ser(input logic [15:0] d, input int len,
                                              input bit fill, input bit msb, input bit low);
        int          n;
        logic [31:0] v;
        logic [31:0] s;
        n = 8 * (len + 1);
        v = '0;
        s = '0;
        for (int b = 0; b < 32; b++) begin
            if (n < DW) begin
                if (b < n) v[5'(b)] = low ? d[4'(DW - n + b)] : d[4'(b)];
            end else if (b < DW) begin
                v[5'(fill ? n - DW + b : b)] = d[4'(b)];
            end
        end
        for (int i = 0; i < n; i++) s[5'(i)] = msb ? v[5'(n - 1 - i)] : v[5'(i)];
        return s;
    endfunction

    function automatic logic [7:0] model_byte(input logic [31:0] s, input int j);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[3'(7 - b)] = s[5'(8 * j + b)];
        return r;
    endfunction

    task automatic push_write(input int c, input logic [7:0] d);
        logic [3:0] bv;
        logic [3:0] o;
        logic [3:0] e;
        bit         is_odd;
        if (mk < MEM_DEPTH) begin
            bv         = '0;
            bv[2'(mk / GRP)] = 1'b1;
            is_odd     = ((mk % 2) == ((mk / 8) % 2));
            o          = is_odd ? bv : 4'h0;
            e          = is_odd ? 4'h0 : bv;
            exp_wr.push_back(pack_wr(c, o, e, 5'((mk % GRP) / 2), d));
            mk++;
        end
    endtask

    // Scoreboard consumer: every valid bit and every strobe pops one expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (so_valid) begin
                if (exp_bits.size() == 0) check("bit_unexpected", 64'(so_valid), 64'(0));
                else check("so_bit", {32'(cyc), 31'(0), so_data}, exp_bits.pop_front());
            end else if (exp_bits.size() != 0 && exp_bits[0][63:32] == 32'(cyc)) begin
                check("bit_missing", 64'(so_valid), 64'(1));
                void'(exp_bits.pop_front());
            end
            if ((odd_wr | even_wr) != '0) begin
                if (exp_wr.size() == 0) check("wr_unexpected", 64'({odd_wr, even_wr}), 64'(0));
                else check("wr", pack_wr(cyc, odd_wr, even_wr, oem_addr, oem_dataout),
                           exp_wr.pop_front());
            end else begin
                if (oem_dataout != 8'h00) check("idle_data", 64'(oem_dataout), 64'(0));
                if (exp_wr.size() != 0 && exp_wr[0][63:32] == 32'(cyc)) begin
                    check("wr_missing", 64'({odd_wr, even_wr}), exp_wr[0][20:13]);
                    void'(exp_wr.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [15:0] d, input int len, input bit fill,
                        input bit msb, input bit low, input bit endf);
        int          waitc;
        int          c;
        int          n;
        int          nxt;
        logic [31:0] s;
        waitc = 0;
        @(negedge clk);
        while (!in_ready && waitc < 2000) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            check("ready_timeout", 64'(in_ready), 64'(1));
            return;
        end
        if (exp_rdy >= 0) check("ready_cycle", 64'(cyc), 64'(exp_rdy));
        c         = cyc;
        pi_data   = d;
        pi_length = LW'(len);
        pi_fill   = fill;
        pi_msb    = msb;
        pi_low    = low;
        pi_end    = endf;
        load      = 1'b1;
        n = 8 * (len + 1);
        s = model_ser(d, len, fill, msb, low);
        for (int i = 0; i < n; i++) exp_bits.push_back({32'(c + 1 + i), 31'(0), s[5'(i)]});
        for (int j = 0; j <= len; j++) push_write(c + 1 + n + j, model_byte(s, j));
        nxt = c + 1 + n + len + 1;
        exp_rdy = endf ? -1 : nxt;
        if (endf) begin
`ifdef STI_DAC_ZERO_FILL_EN
            while (mk < MEM_DEPTH) begin
                push_write(nxt, 8'h00);
                nxt++;
            end
`endif
            exp_fin = nxt;
        end
        @(posedge clk);
        #1 load = 1'b0;
        pi_end = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, 64'({so_data, so_valid, oem_dataout, oem_addr, odd_wr, even_wr, oem_finish}),
              64'(0));
        check({tag, "_ready"}, 64'(in_ready), 64'(1));
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        exp_bits.delete();
        exp_wr.delete();
        mk      = 0;
        exp_rdy = -1;
        exp_fin = -1;
        @(negedge clk);
        check_reset_outputs("reset_outs");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int waitc;
        int hi;
        repeat (3) @(negedge clk);
        check_reset_outputs("init_outs");
        reset = 1'b0;

        // Byte select, then left-justified LSB-first word.
        send(16'hA5C3, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        send(16'h1234, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        send(16'h5A0F, 1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Abort mid-SHIFT; next word must restart at k=0.
        send(16'hBEEF, 1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        do_reset();
        send(16'h00C3, 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Random words up to and beyond MEM_DEPTH (bank crossings, saturation).
        while (mk < MEM_DEPTH)
            send(16'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'b0);
        send(16'hFFFF, 1, 1'b0, 1'b1, 1'b0, 1'b0);
        send(16'h8001, 3, 1'b1, 1'b1, 1'b0, 1'b0);

        // End word: zero fill (if enabled) and sticky finish.
        @(negedge clk);
        do_reset();
        send(16'hC0DE, 3, 1'b0, 1'b1, 1'b0, 1'b1);
        waitc = 0;
        while (!oem_finish && waitc < 2000) begin
            @(negedge clk);
            waitc++;
        end
        check("finish_cycle", 64'(cyc), 64'(exp_fin));
        load    = 1'b1;
        pi_data = 16'hFFFF;
        hi      = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (oem_finish && !in_ready) hi++;
        end
        load = 1'b0;
        check("finish_hold", 64'(hi), 64'(100));
        check("bits_left", 64'(exp_bits.size()), 64'(0));
        check("writes_left", 64'(exp_wr.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
